icu_seq: RTL and testbench

Parametrised interrupt control sequencer for the five-stage pipeline. Latches up to NUM_IRQ external requests, selects the highest-priority unmasked one, and for a fixed multi-cycle sequence takes over the CU's stack, memory and branch controls to push PC and flags and then redirect fetch to a per-channel vector. It sits beside the CU in decode. While its `int_flag` is high, the decode-stage mux selects this block's control outputs instead of the CU's.

---
 rtl/icu_seq.sv | 134 +++++++++++++
 tb/tb_icu_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/icu_seq.sv
// rtl/icu_seq.sv - interrupt control sequencer: latches requests, pushes PC/flags, vectors fetch.
// Optional nested acceptance is enabled by defining ICU_NESTING_EN.
module icu_seq #(
  parameter int                  NUM_IRQ      = 4,
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] VEC_BASE     = '0,
  parameter int                  VEC_STRIDE   = 2,
  parameter int                  DRAIN_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IRQ-1:0]  irq,
  input  logic [NUM_IRQ-1:0]  irq_mask,
  input  logic                int_en,
  input  logic                rti,
  output logic                int_flag,
  output logic                fetch_stall,
  output logic [3:0]          alu_function,
  output logic                branch,
  output logic                DMW,
  output logic                stack_operation,
  output logic                push_pop,
  output logic                write_sp,
  output logic                save_sel,
  output logic [PC_WIDTH-1:0] vector_addr,
  output logic [NUM_IRQ-1:0]  irq_ack,
  output logic [NUM_IRQ-1:0]  in_service
);

  localparam int ID_W  = 4;
  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, DRAIN, PUSH_PC, PUSH_FLG, VECTOR} state_t;

  state_t              state, state_d;
  logic [NUM_IRQ-1:0]  irq_q, pending, eligible, rise, rti_clear, id_onehot;
  logic [ID_W-1:0]     winner, svc_low, id;
  logic [CNT_W-1:0]    cnt;
  logic                any_elig, any_svc, allow, accept, push;
  logic [PC_WIDTH-1:0] vec;

  assign rise      = irq & ~irq_q;
  assign eligible  = pending & ~irq_mask;
  // Isolate the lowest set in-service bit; zero when nothing is in service.
  assign rti_clear = rti ? (in_service & (~in_service + NUM_IRQ'(1))) : '0;
  assign id_onehot = NUM_IRQ'(1) << id;
  assign vec       = VEC_BASE + PC_WIDTH'(id) * PC_WIDTH'(VEC_STRIDE);

  always_comb begin
    winner   = '0;
    any_elig = 1'b0;
    svc_low  = '0;
    any_svc  = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner   = ID_W'(i);
        any_elig = 1'b1;
      end
      if (in_service[i]) begin
        svc_low = ID_W'(i);
        any_svc = 1'b1;
      end
    end
  end

`ifdef ICU_NESTING_EN
  assign allow = !any_svc || (winner < svc_low);
`else
  assign allow = !any_svc;
`endif

  // A coincident rti takes precedence; acceptance is re-evaluated next cycle.
  assign accept = (state == IDLE) && !rti && int_en && any_elig && allow;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (accept) state_d = DRAIN;
      DRAIN:    if (cnt == '0) state_d = PUSH_PC;
      PUSH_PC:  state_d = PUSH_FLG;
      PUSH_FLG: state_d = VECTOR;
      VECTOR:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign push = (state_d == PUSH_PC) || (state_d == PUSH_FLG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      irq_q           <= '0;
      pending         <= '0;
      in_service      <= '0;
      id              <= '0;
      cnt             <= '0;
      int_flag        <= 1'b0;
      fetch_stall     <= 1'b0;
      alu_function    <= 4'b0000;
      branch          <= 1'b0;
      DMW             <= 1'b0;
      stack_operation <= 1'b0;
      push_pop        <= 1'b0;
      write_sp        <= 1'b0;
      save_sel        <= 1'b0;
      vector_addr     <= '0;
      irq_ack         <= '0;
    end else begin
      state      <= state_d;
      irq_q      <= irq;
      pending    <= (pending & ~irq_ack) | rise;
      in_service <= (in_service & ~rti_clear) | ((state_d == VECTOR) ? id_onehot : '0);
      if (accept) begin
        id  <= winner;
        cnt <= CNT_W'(DRAIN_CYCLES - 1);
      end else if (state == DRAIN && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      // Outputs are decoded from the state being entered so they line up with it.
      int_flag        <= state_d != IDLE;
      fetch_stall     <= (state_d == DRAIN) || push;
      alu_function    <= (push || state_d == VECTOR) ? 4'b0100 : 4'b0000;
      branch          <= state_d == VECTOR;
      DMW             <= push;
      stack_operation <= push;
      push_pop        <= push;
      write_sp        <= push;
      save_sel        <= state_d == PUSH_FLG;
      vector_addr     <= (state_d == VECTOR) ? vec : '0;
      irq_ack         <= (state_d == VECTOR) ? id_onehot : '0;
    end
  end

endmodule

// File: tb/tb_icu_seq.sv
// tb/tb_icu_seq.sv - directed and random checks of icu_seq against a timeline reference model.
module tb_icu_seq;
  localparam int          N      = 4;
  localparam int          PCW    = 32;
  localparam int          D      = 3;
  localparam int          STRIDE = 2;
  localparam logic [31:0] BASE   = 32'd0;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   irq = '0;
  logic [N-1:0]   irq_mask = '0;
  logic           int_en = 1'b0;
  logic           rti = 1'b0;
  logic           int_flag, fetch_stall, branch, DMW, stack_operation, push_pop, write_sp, save_sel;
  logic [3:0]     alu_function;
  logic [PCW-1:0] vector_addr;
  logic [N-1:0]   irq_ack, in_service;

  icu_seq #(.NUM_IRQ(N), .PC_WIDTH(PCW), .VEC_BASE(BASE), .VEC_STRIDE(STRIDE), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .irq_mask(irq_mask), .int_en(int_en), .rti(rti),
    .int_flag(int_flag), .fetch_stall(fetch_stall), .alu_function(alu_function), .branch(branch),
    .DMW(DMW), .stack_operation(stack_operation), .push_pop(push_pop), .write_sp(write_sp),
    .save_sel(save_sel), .vector_addr(vector_addr), .irq_ack(irq_ack), .in_service(in_service)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: m_phase counts the cycle within a takeover (0 = not running).
  logic [N-1:0] m_prev, m_pend, m_insvc;
  int           m_phase, m_id;
  int           flag_cnt;
  logic [31:0]  vec_q[$];
  logic         reached;

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return N;
  endfunction

  function automatic bit allowed(input int w);
`ifdef ICU_NESTING_EN
    return w < lowest(m_insvc);
`else
    return m_insvc == '0;
`endif
  endfunction

  function automatic logic [63:0] expected();
    logic        run, br, pu;
    logic [31:0] v;
    logic [N-1:0] a;
    run = m_phase != 0;
    br  = m_phase == D + 3;
    pu  = (m_phase == D + 1) || (m_phase == D + 2);
    v   = br ? BASE + 32'(m_id) * 32'(STRIDE) : 32'd0;
    a   = br ? N'(1) << m_id : '0;
    return 64'({run, run && !br, (m_phase > D) ? 4'b0100 : 4'b0000, br, pu, pu, pu, pu,
                m_phase == D + 2, v, a, m_insvc});
  endfunction

  function automatic logic [63:0] actual();
    return 64'({int_flag, fetch_stall, alu_function, branch, DMW, stack_operation, push_pop,
                write_sp, save_sel, vector_addr, irq_ack, in_service});
  endfunction

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_insvc = '0; m_phase = 0; m_id = 0;
  endtask

  task automatic model_update();
    logic [N-1:0] rise, ack_old, elig, ins;
    int np, nid, w;
    rise    = irq & ~m_prev;
    ack_old = (m_phase == D + 3) ? N'(1) << m_id : '0;
    elig    = m_pend & ~irq_mask;
    np = m_phase; nid = m_id;
    if (m_phase == 0) begin
      if (!rti && int_en && elig != '0) begin
        w = lowest(elig);
        if (allowed(w)) begin np = 1; nid = w; end
      end
    end else if (m_phase == D + 3) np = 0;
    else np = m_phase + 1;
    ins = m_insvc;
    if (rti && ins != '0) ins[lowest(ins)] = 1'b0;
    if (np == D + 3) ins[nid] = 1'b1;
    m_insvc = ins;
    m_pend  = (m_pend & ~ack_old) | rise;
    m_prev  = irq;
    m_phase = np;
    m_id    = nid;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (!rst_n) model_reset(); else model_update();
    #1;
    check(tag, actual(), expected());
    if (int_flag) flag_cnt++;
    if (irq_ack != '0) vec_q.push_back(vector_addr);
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) step(tag);
  endtask

  task automatic pulse_rti(input string tag);
    rti = 1'b1;
    step(tag);
    rti = 1'b0;
  endtask

  function automatic logic [31:0] vec_at(input int i);
    return (vec_q.size() > i) ? vec_q[i] : 32'hdead_beef;
  endfunction

  initial begin
    flag_cnt = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("reset_outputs", actual(), 64'd0);
    run(2, "reset_hold");
    rst_n = 1'b1; int_en = 1'b1;

    // Single request on channel 2.
    irq = 4'b0100; flag_cnt = 0; vec_q.delete();
    run(12, "single");
    check("single_flag_cycles", flag_cnt, 6);
    check("single_ack_count", vec_q.size(), 1);
    check("single_vector", vec_at(0), 4);
    check("single_in_service", in_service, 4'b0100);
    pulse_rti("single_rti"); irq = '0; run(2, "single_idle");
    check("single_cleared", in_service, 0);

    // Two simultaneous requests: priority order then rti releases the next.
    irq = 4'b1010; vec_q.delete();
    run(12, "pair_first");
    check("pair_first_count", vec_q.size(), 1);
    check("pair_first_vector", vec_at(0), 2);
    pulse_rti("pair_rti");
    run(12, "pair_second");
    check("pair_second_vector", vec_at(1), 6);
    pulse_rti("pair_rti2"); irq = '0; run(2, "pair_idle");

    // Masked request is held, then accepted one cycle after unmasking.
    irq_mask = 4'b0001; irq = 4'b0001; flag_cnt = 0;
    run(10, "masked");
    check("masked_no_takeover", flag_cnt, 0);
    irq_mask = '0; vec_q.delete();
    step("unmask");
    check("unmask_start", int_flag, 1);
    run(10, "unmask_seq");
    check("unmask_vector", vec_at(0), 0);
    pulse_rti("unmask_rti"); irq = '0; run(2, "unmask_idle");

    // Higher-priority request while channel 2 is in service.
    irq = 4'b0100; run(10, "nest_base");
    irq = 4'b0101; run(12, "nest_high");
`ifdef ICU_NESTING_EN
    check("nest_in_service", in_service, 4'b0101);
`else
    check("nest_in_service", in_service, 4'b0100);
`endif
    pulse_rti("nest_rti1"); run(12, "nest_after1");
`ifdef ICU_NESTING_EN
    check("nest_after_rti", in_service, 4'b0100);
`else
    check("nest_after_rti", in_service, 4'b0001);
`endif
    pulse_rti("nest_rti2"); run(2, "nest_idle");
    check("nest_cleared", in_service, 0);
    irq = '0; run(2, "nest_drop");

    // Reset asserted during PUSH_PC.
    irq = 4'b0010; reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      step("rst_seq");
      reached = fetch_stall && DMW && !save_sel;
    end
    check("rst_reach_push_pc", reached, 1);
    #3 rst_n = 1'b0;
    #1 model_reset();
    check("rst_async_outputs", actual(), 64'd0);
    irq = '0;
    run(2, "rst_hold");
    rst_n = 1'b1; flag_cnt = 0;
    run(8, "rst_after");
    check("rst_idle_no_pending", flag_cnt, 0);

    // Stray rti with nothing in service while interrupts are disabled.
    int_en = 1'b0; irq = 4'b0010; rti = 1'b1;
    step("stray_rti"); rti = 1'b0; flag_cnt = 0;
    run(6, "disabled");
    check("disabled_no_takeover", flag_cnt, 0);
    check("disabled_in_service", in_service, 0);
    int_en = 1'b1; vec_q.delete();
    run(12, "enable");
    check("enable_count", vec_q.size(), 1);
    check("enable_vector", vec_at(0), 2);
    pulse_rti("enable_rti"); irq = '0; run(2, "enable_idle");

    // Random traffic against the model.
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) irq = irq ^ N'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) irq_mask = N'($urandom_range(0, 15));
      int_en = $urandom_range(0, 7) != 0;
      rti    = $urandom_range(0, 9) == 0;
      step("random");
    end
    rti = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
